mii_frame_gen: RTL and testbench

MII_FRAME_GEN -- requirements
Module: mii_frame_gen

---
 rtl/mii_frame_gen.sv | 112 +++++++++++
 tb/tb_mii_frame_gen.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mii_frame_gen.sv
// mii_frame_gen: emits START/preamble, incrementing payload, TERM and idle gap on a 64-bit MII.
module mii_frame_gen #(
    parameter int DATA_WIDTH = 64,
    parameter int IFG_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [15:0]             frame_len,
    input  logic [7:0]              seed,
    input  logic                    err_inject,
    output logic                    ready,
    output logic [DATA_WIDTH/8-1:0] ctrl_out,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    done,
    output logic [31:0]             frames_sent
);
    localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;
    localparam logic [63:0] START_WORD = 64'hD5555555555555FB;

    typedef enum logic [1:0] {S_IDLE, S_START, S_PAYLOAD, S_IFG} state_t;

    state_t      state, state_nxt;
    logic [15:0] len;
    logic [7:0]  seed_q;
    logic        err_q;
    logic [12:0] word;
    logic [3:0]  gap;
    logic [16:0] k;
    logic [7:0]  ctrl_nxt;
    logic [63:0] data_nxt;
    logic        done_nxt;
    logic        accept, last;

    assign accept = state == S_IDLE && start && frame_len != 16'd0;
    assign last   = word == len[15:3];
    assign ready  = state == S_IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    state_nxt = accept ? S_START : S_IDLE;
            S_START:   state_nxt = S_PAYLOAD;
            S_PAYLOAD: state_nxt = last ? S_IFG : S_PAYLOAD;
            S_IFG:     state_nxt = gap == 4'(IFG_CYCLES - 1) ? S_IDLE : S_IFG;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len    <= '0;
            seed_q <= '0;
            err_q  <= 1'b0;
            word   <= '0;
            gap    <= '0;
        end else begin
            if (accept) begin
                len    <= frame_len;
                seed_q <= seed;
                err_q  <= err_inject;
            end
            word <= state == S_PAYLOAD ? word + 13'd1 : '0;
            gap  <= state == S_IFG ? gap + 4'd1 : '0;
        end
    end

    // Byte index k is 17 bits so the TERM position len=0xFFFF stays representable.
    always_comb begin
        ctrl_nxt = 8'hFF;
        data_nxt = IDLE_WORD;
        done_nxt = 1'b0;
        k        = '0;
        if (state == S_START) begin
            ctrl_nxt = 8'h01;
            data_nxt = START_WORD;
        end else if (state == S_PAYLOAD) begin
            done_nxt = last;
            for (int i = 0; i < 8; i++) begin
                k = {1'b0, word, 3'(i)};
                if (err_q && k == {1'b0, len} - 17'd1) begin
                    ctrl_nxt[i]         = 1'b1;
                    data_nxt[8*i +: 8] = 8'hFE;
                end else if (k < {1'b0, len}) begin
                    ctrl_nxt[i]         = 1'b0;
                    data_nxt[8*i +: 8] = seed_q + k[7:0];
                end else if (k == {1'b0, len}) begin
                    data_nxt[8*i +: 8] = 8'hFD;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_out    <= '1;
            data_out    <= IDLE_WORD;
            done        <= 1'b0;
            frames_sent <= '0;
        end else begin
            ctrl_out    <= ctrl_nxt;
            data_out    <= data_nxt;
            done        <= done_nxt;
            frames_sent <= frames_sent + {31'd0, done_nxt};
        end
    end
endmodule

// File: tb/tb_mii_frame_gen.sv
// tb_mii_frame_gen: randomized frames checked against a byte-stream reference model.
module tb_mii_frame_gen;
    localparam int IFG = 1;
    localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
    localparam logic [63:0] START_W = 64'hD5555555555555FB;

    logic        clk = 0, rst = 1, start = 0, err_inject = 0;
    logic [15:0] frame_len = 0;
    logic [7:0]  seed = 0;
    logic        ready, done;
    logic [7:0]  ctrl_out;
    logic [63:0] data_out;
    logic [31:0] frames_sent;

    int checks = 0, errors = 0;
    int fs = 0;

    mii_frame_gen #(.DATA_WIDTH(64), .IFG_CYCLES(IFG)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .seed(seed),
        .err_inject(err_inject), .ready(ready), .ctrl_out(ctrl_out), .data_out(data_out),
        .done(done), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctrl"}, 64'(ctrl_out), 64'hFF);
        chk({tag, "_data"}, data_out, IDLE_W);
        chk({tag, "_done"}, 64'(done), 0);
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
    task automatic send(input int len, input logic [7:0] sd, input logic er);
        logic [8:0] q[$];
        int nw;
        logic [7:0]  ec;
        logic [63:0] ed;
        for (int k = 0; k < len; k++) q.push_back({1'b0, 8'(sd + k)});
        if (er) q[len-1] = {1'b1, 8'hFE};
        q.push_back({1'b1, 8'hFD});
        while (q.size() % 8 != 0) q.push_back({1'b1, 8'h07});
        nw = q.size() / 8;
        chk("ready_pre", 64'(ready), 1);
        start = 1; frame_len = 16'(len); seed = sd; err_inject = er;
        @(negedge clk);
        chk("ready_busy", 64'(ready), 0);
        start = 1'($urandom); frame_len = 16'($urandom); seed = 8'($urandom); err_inject = 1'($urandom);
        @(negedge clk);
        chk("start_ctrl", 64'(ctrl_out), 64'h01);
        chk("start_data", data_out, START_W);
        chk("start_done", 64'(done), 0);
        for (int j = 0; j < nw; j++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                ec[i] = q[8*j+i][8];
                ed[8*i +: 8] = q[8*j+i][7:0];
            end
            chk("pl_ctrl", 64'(ctrl_out), 64'(ec));
            chk("pl_data", data_out, ed);
            chk("pl_done", 64'(done), 64'(j == nw - 1));
            if (j == nw - 1) begin
                fs++;
                chk("frames_sent", 64'(frames_sent), 64'(fs));
                start = 0;
            end
        end
        for (int g = 0; g < IFG; g++) begin
            @(negedge clk);
            chk_idle("ifg");
        end
        chk("ready_post", 64'(ready), 1);
    endtask

    initial begin
        int nstarts, term_c;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk("reset_fs", 64'(frames_sent), 0);
        chk("reset_ready", 64'(ready), 1);
        rst = 0;
        send(3, 8'h10, 0);
        send(8, 8'hFE, 0);
        send(2, 8'h20, 1);
        send(1, 8'h33, 1);
        // zero-length request is dropped
        start = 1; frame_len = 0;
        @(negedge clk);
        start = 0;
        chk("len0_ready", 64'(ready), 1);
        chk_idle("len0");
        @(negedge clk);
        chk_idle("len0b");
        chk("len0_fs", 64'(frames_sent), 64'(fs));
        for (int n = 0; n < 25; n++)
            send($urandom_range(1, 40), 8'($urandom), 1'($urandom_range(0, 3) == 0));
        // reset mid-frame acts without a clock edge
        start = 1; frame_len = 40; seed = 8'h5A; err_inject = 0;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        #2 rst = 1;
        #1;
        chk_idle("rst_mid");
        chk("rst_mid_fs", 64'(frames_sent), 0);
        chk("rst_mid_ready", 64'(ready), 1);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_done", 64'(done), 0);
        end
        rst = 0; fs = 0;
        send(40, 8'h5A, 0);
        // back-to-back with start held high
        start = 1; frame_len = 16; seed = 8'($urandom); err_inject = 0;
        nstarts = 0; term_c = -1;
        for (int c = 0; c < 80 && nstarts < 3; c++) begin
            @(negedge clk);
            if (ctrl_out == 8'h01 && data_out == START_W) begin
                nstarts++;
                if (term_c >= 0) chk("b2b_gap", 64'(c - term_c), 64'(IFG + 2));
            end
            if (done) begin
                fs++;
                term_c = c;
                chk("b2b_fs", 64'(frames_sent), 64'(fs));
            end
        end
        chk("b2b_starts", 64'(nstarts), 3);
        start = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) fs++;
        end
        chk("b2b_final_fs", 64'(frames_sent), 64'(fs));
        chk("b2b_ready", 64'(ready), 1);
        send(16'hFFFF, 8'h01, 0);
        send(5, 8'hFF, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
